// File: rtl/pipeline_hazard_pkg.sv
// Shared types and encodings for the RV32I hazard/stall controller.
package pipeline_hazard_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      WAIT    = 2'd1,
      RELEASE = 2'd2
   } state_e;

   localparam logic [1:0] FWD_RF        = 2'b00;
   localparam logic [1:0] FWD_WB        = 2'b01;
   localparam logic [1:0] FWD_MEM       = 2'b10;
   localparam logic [1:0] MEMTOREG_LOAD = 2'b01;

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// EX-stage operand forwarding select for one source register; MEM beats WB.
module forward_unit
   import pipeline_hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] RsE,
   input  logic [REG_ADDR_W-1:0] RdM,
   input  logic [REG_ADDR_W-1:0] RdW,
   input  logic                  RegWriteM,
   input  logic                  RegWriteW,
   output logic [1:0]            ForwardE
);

   always_comb begin
      ForwardE = FWD_RF;
      if (RegWriteM && (RdM != '0) && (RdM == RsE)) begin
         ForwardE = FWD_MEM;
      end else if (RegWriteW && (RdW != '0) && (RdW == RsE)) begin
         ForwardE = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller: forwarding, load-use stall, branch flush and
// slow-peripheral MEM-stage freeze with req/ack handshake and timeout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal flow; PeriphAccM freezes the pipe and enters WAIT
// WAIT    | periph_req high, pipe frozen, waiting for ack or timeout
// RELEASE | one unfrozen cycle, ReadDataM taken from periph_hold
//
// Integrator note: StallF may assert together with PCSrcE (load-use plus
// taken branch); the PC register enable must be gated with PCSrcE.
module pipeline_hazard_ctrl
   import pipeline_hazard_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_W     = 5,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] Rs1D,
   input  logic [REG_ADDR_W-1:0] Rs2D,
   input  logic [REG_ADDR_W-1:0] Rs1E,
   input  logic [REG_ADDR_W-1:0] Rs2E,
   input  logic [REG_ADDR_W-1:0] RdE,
   input  logic [REG_ADDR_W-1:0] RdM,
   input  logic [REG_ADDR_W-1:0] RdW,
   input  logic                  RegWriteM,
   input  logic                  RegWriteW,
   input  logic [1:0]            MemtoRegE,
   input  logic                  PCSrcE,
   input  logic                  PeriphAccM,
   input  logic                  periph_ack,
   input  logic [DATA_WIDTH-1:0] periph_rdata,
   output logic [1:0]            ForwardAE,
   output logic [1:0]            ForwardBE,
   output logic                  StallF,
   output logic                  StallD,
   output logic                  StallE,
   output logic                  StallM,
   output logic                  FlushD,
   output logic                  FlushE,
   output logic                  FlushW,
   output logic                  periph_req,
   output logic                  periph_data_sel,
   output logic [DATA_WIDTH-1:0] periph_hold,
   output logic                  timeout_err
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  req_q, req_d;
   logic                  sel_q, sel_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  terr_q, terr_d;
   logic                  memstall;
   logic                  lwstall;

   forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .RsE(Rs1E), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ForwardE(ForwardAE)
   );

   forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .RsE(Rs2E), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ForwardE(ForwardBE)
   );

   assign lwstall = (MemtoRegE == MEMTOREG_LOAD) && (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hold_d   = hold_q;
      terr_d   = terr_q;
      memstall = 1'b0;
      case (state_q)
         RUN: begin
            cnt_d = '0;
            if (PeriphAccM) begin
               memstall = 1'b1;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            memstall = 1'b1;
            cnt_d    = cnt_q + CNT_WIDTH'(1);
            // ack on the final counted cycle still completes normally
            if (periph_ack) begin
               hold_d  = periph_rdata;
               state_d = RELEASE;
            end else if (cnt_q == CNT_LAST) begin
               hold_d  = '0;
               terr_d  = 1'b1;
               state_d = RELEASE;
            end
         end
         RELEASE: state_d = RUN;
         default: state_d = RUN;
      endcase
      req_d = (state_d == WAIT);
      sel_d = (state_d == RELEASE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         sel_q   <= 1'b0;
         hold_q  <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         sel_q   <= sel_d;
         hold_q  <= hold_d;
         terr_q  <= terr_d;
      end
   end

   assign StallM = memstall;
   assign StallE = memstall;
   assign StallF = memstall | lwstall;
   assign StallD = memstall | lwstall;
   assign FlushW = memstall;
   assign FlushE = ~memstall & (lwstall | PCSrcE);
   assign FlushD = ~memstall & PCSrcE;

   assign periph_req      = req_q;
   assign periph_data_sel = sel_q;
   assign periph_hold     = hold_q;
   assign timeout_err     = terr_q;

endmodule
